reaction_sequencer: RTL
=======================

REACTION_SEQUENCER -- requirements
Module: reaction_sequencer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 1000, number of tick_1ms pulses per second of random delay.
REQ-002 Parameter BEST_INIT, default 16'h9999, BCD reset value of the best score.
REQ-003 CLK_10MHZ  in  1  sole clock; one clock; all logic on its rising edge.
REQ-004 RESET_N  in  1  reset, synchronous and active-low.
REQ-005 tick_1ms  in  1  one-cycle enable pulse at 1 kHz.
REQ-006 arm  in  1  game enable switch (SW[0]); low forces IDLE.
REQ-007 start_n  in  1  active-low start button (KEY0), already synchronised.
REQ-008 stop_sw  in  9  player stop switches, bit i maps to LEDR[i+1].
REQ-009 rand_delay  in  4  free-running LFSR value for delay.
REQ-010 rand_led  in  4  free-running LFSR value for LED choice.
REQ-011 time_bcd  in  16  external BCD counter value, [15:12] thousands to [3:0] units.
REQ-012 cnt_clr  out  1  synchronous clear to BCD counter.
REQ-013 cnt_en  out  1  count enable to BCD counter (counter advances on tick_1ms).
REQ-014 lfsr_en  out  1  LFSR run enable.
REQ-015 led_sel  out  9  one-hot target LED (LEDR[9:1]), zero when none.
REQ-016 disp_bcd  out  16  four BCD digits for the HEX3..HEX0 decoders.
REQ-017 best_bcd  out  16  registered best score.
REQ-018 state_o  out  3  current state encoding, for debug.
REQ-019 false_start  out  1  high while in FALSE state.

Function
REQ-020 States: IDLE=0, ARMED=1, WAIT=2, REACT=3, DONE=4, FALSE=5; all outputs registered, one-cycle latency from the state change.
REQ-021 IDLE: disp_bcd=best_bcd, cnt_clr=1, lfsr_en=1, led_sel=0; arm=1 -> ARMED.
REQ-022 ARMED: disp_bcd=0000, cnt_clr=1, lfsr_en=1; falling edge of start_n (prev 1, now 0) -> WAIT, capturing delay_s=rand_delay[2:0]+1 (1..8 s) and led_idx=rand_led mod 9 (0..8) in the same cycle.
REQ-023 ARMED requires all stop_sw=0 to accept start; start with any stop_sw set is ignored.
REQ-024 WAIT: lfsr_en=0, disp_bcd=0000; internal tick counter counts TICKS_PER_SEC tick_1ms pulses per second; after delay_s seconds -> REACT.
REQ-025 WAIT: any stop_sw bit set -> FALSE (early reaction).
REQ-026 REACT: led_sel=1<<led_idx, cnt_clr=0, cnt_en=1, disp_bcd=time_bcd.
REQ-027 REACT: stop_sw[led_idx]=1 -> DONE, cnt_en=0 from the next cycle; stop_sw bits other than led_idx are ignored.
REQ-028 REACT: time_bcd=9999 -> DONE with no best update (timeout).
REQ-029 DONE: cnt_en=0, disp_bcd=frozen time_bcd, led_sel=0; on entry, if time_bcd != 0 and time_bcd < best_bcd (unsigned compare of 16-bit BCD), best_bcd<=time_bcd, exactly once per game.
REQ-030 FALSE: disp_bcd=16'hEEEE, led_sel=9'h1FF, false_start=1, best unchanged.
REQ-031 DONE or FALSE: all stop_sw=0 then start_n falling edge -> ARMED (new round).
REQ-032 arm=0 in any state -> IDLE next cycle; has priority over every other transition.
REQ-033 Simultaneous target stop and timeout in REACT: stop wins, best update rules of REQ-029 apply.
REQ-034 Illegal state encodings -> IDLE next cycle.

Reset
REQ-035 RESET_N=0 at a clock edge: state=IDLE, best_bcd=BEST_INIT, tick/second counters=0, led_idx=0, delay_s=1, start edge register=1, cnt_clr=1, cnt_en=0, lfsr_en=1, led_sel=0, false_start=0, disp_bcd=BEST_INIT.
REQ-036 Reset mid-game discards the round; best_bcd also returns to BEST_INIT.

Structure
REQ-037 Shared package holds state encodings, BEST_INIT, the FALSE display code 16'hEEEE and the 9999 timeout constant.
REQ-038 One sub-module, delay_timer (tick and second counting, done pulse), instantiated once; remainder is a single FSM.

Verification
REQ-039 Reset, arm=1, start press with rand_delay=4'd2, rand_led=4'd4 -> REACT after 3*TICKS_PER_SEC ticks, led_sel=9'b000010000.
REQ-040 In REACT, stop_sw[4] set when time_bcd=0x0250 with best 9999 -> DONE, disp_bcd=0x0250, best_bcd=0x0250.
REQ-041 Next round result 0x0300 -> best_bcd stays 0x0250; result 0x0000 -> no update.
REQ-042 stop_sw[0] set during WAIT -> FALSE, disp_bcd=EEEE, false_start=1, best unchanged.
REQ-043 rand_led=4'd13 -> led_idx=4, led_sel=9'b000010000; wrong switch stop_sw[0] in REACT -> stays REACT.
REQ-044 arm deasserted in REACT -> IDLE next cycle, cnt_clr=1, disp_bcd=best_bcd; RESET_N low mid-WAIT -> all REQ-035 values.

Source files
------------

// File: rtl/reaction_sequencer_pkg.sv
// Reaction-timer game: shared state encodings, display
// constants and small helpers for the sequencer.
package reaction_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_WAIT  = 3'd2,
        ST_REACT = 3'd3,
        ST_DONE  = 3'd4,
        ST_FALSE = 3'd5
    } state_e;

    localparam logic [15:0] BEST_INIT_DEF = 16'h9999;
    localparam logic [15:0] FALSE_CODE    = 16'hEEEE;
    localparam logic [15:0] TIMEOUT_BCD   = 16'h9999;
    localparam int          NUM_LEDS      = 9;

    function automatic logic [3:0] mod9(input logic [3:0] v);
        return (v >= 4'd9) ? v - 4'd9 : v;
    endfunction

    function automatic logic [3:0] delay_secs(input logic [2:0] v);
        return {1'b0, v} + 4'd1;
    endfunction

endpackage

// File: rtl/reaction_sequencer_delay_timer.sv
// Random-delay timer: counts tick pulses into seconds while
// running and pulses o_done on the last tick of the delay.
module reaction_sequencer_delay_timer #(
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_run,
    input  logic       i_tick,
    input  logic [3:0] i_secs,
    output logic       o_done
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [3:0]    r_sec_cnt;
    logic          w_sec_end;

    assign w_sec_end = (r_tick_cnt == TICK_LAST);
    assign o_done    = i_run && i_tick && w_sec_end
                    && (r_sec_cnt == i_secs - 4'd1);

    // Counters sit at zero whenever the timer is not running.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            r_sec_cnt  <= '0;
        end else if (!i_run) begin
            r_tick_cnt <= '0;
            r_sec_cnt  <= '0;
        end else if (i_tick) begin
            if (w_sec_end) begin
                r_tick_cnt <= '0;
                r_sec_cnt  <= r_sec_cnt + 4'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/reaction_sequencer.sv
// Reaction-timer game sequencer: arms, waits a random delay,
// lights a target LED, times the response and keeps the best.
module reaction_sequencer
    import reaction_sequencer_pkg::*;
#(
    parameter int          TICKS_PER_SEC = 1000,
    parameter logic [15:0] BEST_INIT     = BEST_INIT_DEF
) (
    input  logic        CLK_10MHZ,
    input  logic        RESET_N,
    input  logic        tick_1ms,
    input  logic        arm,
    input  logic        start_n,
    input  logic [8:0]  stop_sw,
    input  logic [3:0]  rand_delay,
    input  logic [3:0]  rand_led,
    input  logic [15:0] time_bcd,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic        lfsr_en,
    output logic [8:0]  led_sel,
    output logic [15:0] disp_bcd,
    output logic [15:0] best_bcd,
    output logic [2:0]  state_o,
    output logic        false_start
);

    state_e      r_state;
    state_e      w_next;
    logic        r_start_prev;
    logic [3:0]  r_delay_s;
    logic [3:0]  r_led_idx;
    logic [15:0] r_best;
    logic [15:0] r_result;

    logic        r_cnt_clr;
    logic        r_cnt_en;
    logic        r_lfsr_en;
    logic [8:0]  r_led_sel;
    logic [15:0] r_disp;
    logic        r_false;

    logic        w_cnt_clr;
    logic        w_cnt_en;
    logic        w_lfsr_en;
    logic [8:0]  w_led_sel;
    logic [15:0] w_disp;
    logic        w_false;

    logic        w_fall;
    logic        w_sw_idle;
    logic [8:0]  w_target;
    logic        w_hit;
    logic        w_timer_done;
    logic        w_capture;
    logic        w_result_ld;
    logic        w_best_upd;
    logic        w_unused;

    assign w_unused  = rand_delay[3];
    assign w_fall    = r_start_prev & ~start_n;
    assign w_sw_idle = ~|stop_sw;
    assign w_target  = 9'(1) << r_led_idx;
    assign w_hit     = |(stop_sw & w_target);

    reaction_sequencer_delay_timer #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_delay_timer (
        .i_clk  (CLK_10MHZ),
        .i_rst_n(RESET_N),
        .i_run  (r_state == ST_WAIT),
        .i_tick (tick_1ms),
        .i_secs (r_delay_s),
        .o_done (w_timer_done)
    );

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_result_ld = 1'b0;
        w_best_upd  = 1'b0;
        w_cnt_clr   = 1'b1;
        w_cnt_en    = 1'b0;
        w_lfsr_en   = 1'b1;
        w_led_sel   = '0;
        w_disp      = 16'h0000;
        w_false     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_disp = r_best;
                w_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_fall && w_sw_idle) begin
                    w_next    = ST_WAIT;
                    w_capture = 1'b1;
                end
            end
            ST_WAIT: begin
                w_lfsr_en = 1'b0;
                if (!w_sw_idle) begin
                    w_next = ST_FALSE;
                end else if (w_timer_done) begin
                    w_next = ST_REACT;
                end
            end
            ST_REACT: begin
                w_lfsr_en = 1'b0;
                w_cnt_clr = 1'b0;
                w_cnt_en  = 1'b1;
                w_led_sel = w_target;
                w_disp    = time_bcd;
                // A target hit outranks a simultaneous timeout.
                if (w_hit) begin
                    w_next      = ST_DONE;
                    w_result_ld = 1'b1;
                    w_best_upd  = (time_bcd != 16'h0000)
                               && (time_bcd < r_best);
                end else if (time_bcd == TIMEOUT_BCD) begin
                    w_next      = ST_DONE;
                    w_result_ld = 1'b1;
                end
            end
            ST_DONE: begin
                w_cnt_clr = 1'b0;
                w_disp    = r_result;
                if (w_fall && w_sw_idle) begin
                    w_next = ST_ARMED;
                end
            end
            ST_FALSE: begin
                w_disp    = FALSE_CODE;
                w_led_sel = '1;
                w_false   = 1'b1;
                if (w_fall && w_sw_idle) begin
                    w_next = ST_ARMED;
                end
            end
            default: begin
                w_disp = r_best;
                w_next = ST_IDLE;
            end
        endcase
        if (!arm) begin
            w_next      = ST_IDLE;
            w_capture   = 1'b0;
            w_result_ld = 1'b0;
            w_best_upd  = 1'b0;
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (!RESET_N) begin
            r_state      <= ST_IDLE;
            r_start_prev <= 1'b1;
            r_delay_s    <= 4'd1;
            r_led_idx    <= 4'd0;
            r_best       <= BEST_INIT;
            r_result     <= 16'h0000;
            r_cnt_clr    <= 1'b1;
            r_cnt_en     <= 1'b0;
            r_lfsr_en    <= 1'b1;
            r_led_sel    <= '0;
            r_disp       <= BEST_INIT;
            r_false      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_start_prev <= start_n;
            if (w_capture) begin
                r_delay_s <= delay_secs(rand_delay[2:0]);
                r_led_idx <= mod9(rand_led);
            end
            if (w_result_ld) begin
                r_result <= time_bcd;
            end
            if (w_best_upd) begin
                r_best <= time_bcd;
            end
            r_cnt_clr <= w_cnt_clr;
            r_cnt_en  <= w_cnt_en;
            r_lfsr_en <= w_lfsr_en;
            r_led_sel <= w_led_sel;
            r_disp    <= w_disp;
            r_false   <= w_false;
        end
    end

    assign cnt_clr     = r_cnt_clr;
    assign cnt_en      = r_cnt_en;
    assign lfsr_en     = r_lfsr_en;
    assign led_sel     = r_led_sel;
    assign disp_bcd    = r_disp;
    assign best_bcd    = r_best;
    assign state_o     = r_state;
    assign false_start = r_false;

endmodule
